// File: rtl/interconn_recv_buffer.sv
// Receive-side burst FIFO draining into the MVU data-memory write port.
// Optional source filter enabled by INTERCONN_RECV_SRC_FILTER_EN.
module interconn_recv_buffer #(
   parameter int N     = 8,
   parameter int W     = 64,
   parameter int BADDR = 15,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [N-1:0]             recv_from,
   input  logic                     recv_en,
   input  logic [BADDR-1:0]         recv_addr,
   input  logic [W-1:0]             recv_word,
   input  logic                     mem_busy,
   input  logic                     ovf_clr,
`ifdef INTERCONN_RECV_SRC_FILTER_EN
   input  logic [N-1:0]             src_mask,
   output logic [7:0]               filt_cnt,
`endif
   output logic                     mem_wr_en,
   output logic [BADDR-1:0]         mem_wr_addr,
   output logic [W-1:0]             mem_wr_data,
   output logic [N-1:0]             mem_wr_src,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = N + BADDR + W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0] store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt_nxt;
   logic [EW-1:0] head;
   logic          cand;
   logic          push;
   logic          pop;
   logic          drop;

`ifdef INTERCONN_RECV_SRC_FILTER_EN
   logic pass;
   logic filt;

   assign pass = |(recv_from & src_mask);
   assign filt = recv_en & ~pass;
   assign cand = recv_en & pass;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         filt_cnt <= '0;
      end else if (filt && filt_cnt != 8'hff) begin
         filt_cnt <= filt_cnt + 8'd1;
      end
   end
`else
   assign cand = recv_en;
`endif

   // Full FIFO still accepts when the head leaves on the same edge.
   assign pop  = (fifo_count != '0) && !mem_busy;
   assign push = cand && ((fifo_count != DEPTH_C) || pop);
   assign drop = cand && (fifo_count == DEPTH_C) && !pop;
   assign head = store[rd_ptr];

   always_comb begin
      cnt_nxt = fifo_count;
      unique case (1'b1)
         push && !pop: cnt_nxt = fifo_count + CW'(1);
         pop && !push: cnt_nxt = fifo_count - CW'(1);
         default:      cnt_nxt = fifo_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         store[wr_ptr] <= {recv_from, recv_addr, recv_word};
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= cnt_nxt;
         full       <= (cnt_nxt == DEPTH_C);
         empty      <= (cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_wr_src  <= '0;
      end else begin
         mem_wr_en <= pop;
         if (pop) begin
            {mem_wr_src, mem_wr_addr, mem_wr_data} <= head;
         end
      end
   end

   // A drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: doc/interconn_recv_buffer.md
Name: interconn_recv_buffer

Overview:
- Per-MVU receive-side stage directly downstream of interconn_priority; one instance per MVU.
- Captures every word delivered on that MVU's recv_* port into a small FIFO.
- Drains the FIFO into the MVU's local data-memory write port whenever the MVU's own datapath is not using that port (mem_busy low).
- The interconnect has no backpressure, so this block absorbs bursts and flags any word it has to drop.

Parameters:
- N, 8, number of MVUs; width of the source selector.
- W, 64, data word width.
- BADDR, 15, memory address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock.
- clr  input  1  asynchronous, active-low reset.
- recv_from  input  N  one-hot source MVU of the incoming word.
- recv_en  input  1  incoming word valid this cycle.
- recv_addr  input  BADDR  destination memory address.
- recv_word  input  W  incoming data.
- mem_busy  input  1  local datapath owns the write port this cycle.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_addr  output  BADDR  memory write address.
- mem_wr_data  output  W  memory write data.
- mem_wr_src  output  N  source selector of the word being written.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky drop flag.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (clr low, asynchronous):
  - FIFO pointers and count go to 0; stored contents are discarded.
  - mem_wr_en=0; mem_wr_addr, mem_wr_data, mem_wr_src = 0.
  - empty=1, full=0, overflow=0.
  - Asserting reset mid-drain aborts the drain immediately; no partial write.
- Each FIFO entry holds {recv_from, recv_addr, recv_word} (N+BADDR+W bits).
- Push, evaluated at every rising edge:
  - recv_en=1 and (count<DEPTH, or a pop occurs on the same edge) → entry written at the write pointer.
- Pop, evaluated at every rising edge:
  - count>0 and mem_busy=0 → head entry loads the output registers, mem_wr_en=1 for the following cycle, read pointer advances.
  - Otherwise mem_wr_en=0 for the following cycle; addr/data/src hold their previous values.
- Latency: word sampled at edge k, mem_busy low at edge k+1 → mem_wr_en high in cycle k+1..k+2. There is no combinational bypass.
- Simultaneous push and pop:
  - count unchanged.
  - Legal when full: a push while full is accepted only if a pop occurs on the same edge.
- Overflow: recv_en=1, count==DEPTH and no pop → word dropped, FIFO contents unchanged, overflow set on that edge.
- ovf_clr=1 clears overflow on the next edge. If a drop happens on the same edge, set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. count is tracked separately, so full and empty are never ambiguous.
- FIFO order is strictly preserved. There is no reordering by source or address.
- recv_from is passed through unchecked; a zero or multi-hot value is stored as received.
- full, empty and fifo_count are registered and reflect post-edge state.

Optional Feature:
- Macro: INTERCONN_RECV_SRC_FILTER_EN.
- Defined:
  - Adds input src_mask[N-1:0].
  - An incoming word with (recv_from & src_mask)==0 is discarded before the push; it does not set overflow.
  - Adds output filt_cnt[7:0], incremented per discarded word, saturating at 255, reset to 0.
- Not defined: src_mask and filt_cnt are absent and every recv_en word is a push candidate.

Test Plan:
1. Single word: recv_en 1 cycle, from=8'h04, addr=15'h0012, word=64'hdeadbeefdeadbeef, mem_busy=0 → exactly one mem_wr_en pulse 2 edges later with matching addr, data and src=8'h04; count returns to 0.
2. Burst under busy: mem_busy=1, push 4 words addr 1..4 → full=1, no write. Drop mem_busy → 4 consecutive writes, addr 1,2,3,4 in order; empty=1 afterwards.
3. Overflow: mem_busy=1, push 5 words → 5th dropped, overflow=1, count=4, drained addresses 1..4 only. Pulse ovf_clr → overflow=0.
4. Full with simultaneous push/pop: FIFO full, mem_busy=0, recv_en held for 8 cycles → no drop, overflow stays 0, count stays 4, 12 writes total in order.
5. Reset mid-drain: 3 entries queued, draining; clr low between edges → mem_wr_en=0 and count=0 immediately. After release, no stale writes appear.
6. With INTERCONN_RECV_SRC_FILTER_EN: src_mask=8'h0F, words from 8'h10 and 8'h01 → only the 8'h01 word is written; filt_cnt=1.
